// File: rtl/adc_dac_avg_loop_pkg.sv
// adc_dac_avg_loop_pkg
// Shared constants and types for the block-averaging ADC-to-DAC calibration loop.
// Holds the data widths, the CFG word map, the Q16.16 shift, the GPIO bit
// positions, the captured-coefficient struct and a CFG word extraction helper.
package adc_dac_avg_loop_pkg;

    localparam int FLOAT_WIDTH = 32;
    localparam int ADC_WIDTH   = 12;
    localparam int DAC_WIDTH   = 14;
    localparam int GPIO_WIDTH  = 32;
    localparam int AVG_LOG2    = 10;
    localparam int CFG_WIDTH   = 1024;

    // The accumulator is wide enough to hold 2^AVG_LOG2 full-scale samples.
    localparam int ACC_WIDTH   = ADC_WIDTH + AVG_LOG2;

    localparam int W_DAC_GAIN  = 0;
    localparam int W_DAC_OFS   = 1;
    localparam int W_ADC_GAIN  = 2;
    localparam int W_ADC_OFS   = 3;

    localparam int Q_SHIFT     = 16;

    localparam int GP_EN_BIT     = 31;
    localparam int GP_CNT_LSB    = 12;
    localparam int GP_CNT_MSB    = 30;
    localparam int BLK_CNT_WIDTH = GP_CNT_MSB - GP_CNT_LSB + 1;

    // Coefficients frozen at block capture so the pipeline is immune to
    // CFG changes that arrive while a block is still in flight.
    typedef struct packed {
        logic [FLOAT_WIDTH-1:0] dac_gain;
        logic [FLOAT_WIDTH-1:0] dac_ofs;
        logic [FLOAT_WIDTH-1:0] adc_gain;
        logic [FLOAT_WIDTH-1:0] adc_ofs;
    } coef_t;

    function automatic logic [FLOAT_WIDTH-1:0] cfg_word(input logic [CFG_WIDTH-1:0] cfg,
                                                         input int idx);
        return cfg[idx*FLOAT_WIDTH +: FLOAT_WIDTH];
    endfunction

endpackage

// File: rtl/adc_dac_avg_loop_if.sv
// adc_dac_avg_loop_if
// Bundles the configuration, sample, GPIO and DAC signals of the averaging loop.
//   master : drives CFG_IN, ADC_DATA_IN, GP_IN; observes GP_OUT, DONE, DAC codes
//   slave  : the loop itself (consumes inputs, produces GP_OUT/DONE/DAC codes)
interface adc_dac_avg_loop_if;
    import adc_dac_avg_loop_pkg::*;

    logic [CFG_WIDTH-1:0]  CFG_IN;
    logic [ADC_WIDTH-1:0]  ADC_DATA_IN;
    logic [GPIO_WIDTH-1:0] GP_IN;
    logic [GPIO_WIDTH-1:0] GP_OUT;
    logic                  DONE;
    logic [DAC_WIDTH-1:0]  DACA_CODE_OUT;
    logic [DAC_WIDTH-1:0]  DACB_CODE_OUT;

    modport master (
        output CFG_IN, ADC_DATA_IN, GP_IN,
        input  GP_OUT, DONE, DACA_CODE_OUT, DACB_CODE_OUT
    );

    modport slave (
        input  CFG_IN, ADC_DATA_IN, GP_IN,
        output GP_OUT, DONE, DACA_CODE_OUT, DACB_CODE_OUT
    );

endinterface

// File: rtl/adc_dac_avg_loop_cal_mul_sat.sv
// adc_dac_avg_loop_cal_mul_sat
// Registered calibration stage: y = sat(((x * gain) >>> 16) + offset).
//   clk, rst : clock and synchronous active-high reset
//   load     : y takes the new result only when high, otherwise holds
//   x        : unsigned input code (IN_WIDTH)
//   gain     : unsigned Q16.16 gain
//   offset   : signed integer offset
//   y        : result clamped to 0 .. 2^OUT_WIDTH-1
module adc_dac_avg_loop_cal_mul_sat
    import adc_dac_avg_loop_pkg::*;
#(
    parameter int IN_WIDTH  = 12,
    parameter int OUT_WIDTH = 12
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   load,
    input  logic [IN_WIDTH-1:0]    x,
    input  logic [FLOAT_WIDTH-1:0] gain,
    input  logic [FLOAT_WIDTH-1:0] offset,
    output logic [OUT_WIDTH-1:0]   y
);

    localparam int OP_WIDTH   = FLOAT_WIDTH + 1;
    localparam int PROD_WIDTH = 2 * OP_WIDTH;
    localparam int SUM_WIDTH  = PROD_WIDTH + 1;
    localparam logic [SUM_WIDTH-1:0] Y_MAX =
        {{(SUM_WIDTH-OUT_WIDTH){1'b0}}, {OUT_WIDTH{1'b1}}};

    logic signed [OP_WIDTH-1:0]   x_s;
    logic signed [OP_WIDTH-1:0]   g_s;
    logic signed [PROD_WIDTH-1:0] prod;
    logic signed [SUM_WIDTH-1:0]  shifted;
    logic signed [SUM_WIDTH-1:0]  ofs_s;
    logic signed [SUM_WIDTH-1:0]  sum;
    logic [OUT_WIDTH-1:0]         y_next;

    // Both operands are zero-extended into signed words so the product and the
    // floor shift stay in signed arithmetic; clamping happens after the offset.
    always_comb begin
        x_s     = $signed({{(OP_WIDTH-IN_WIDTH){1'b0}}, x});
        g_s     = $signed({1'b0, gain});
        prod    = PROD_WIDTH'(x_s) * PROD_WIDTH'(g_s);
        shifted = $signed({prod[PROD_WIDTH-1], prod}) >>> Q_SHIFT;
        ofs_s   = $signed({{(SUM_WIDTH-FLOAT_WIDTH){offset[FLOAT_WIDTH-1]}}, offset});
        sum     = shifted + ofs_s;
        y_next  = sum[OUT_WIDTH-1:0];
        if (sum < 0) begin
            y_next = '0;
        end else if (sum > $signed(Y_MAX)) begin
            y_next = '1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            y <= '0;
        end else if (load) begin
            y <= y_next;
        end
    end

endmodule

// File: rtl/adc_dac_avg_loop.sv
// adc_dac_avg_loop
// Sums 2^AVG_LOG2 ADC samples, averages, applies ADC gain/offset, scales to DAC
// width and applies DAC-A gain/offset. DACA_CODE_OUT and GP_OUT update once per
// block together with a one-cycle DONE pulse, four clocks after block capture.
//   ADC_CLK : sole clock
//   RST     : synchronous active-high reset
//   bus     : CFG_IN (w0 GA, w1 OA, w2 GC, w3 OC), ADC_DATA_IN, GP_IN
//             ([31] run enable, [13:0] DAC-B code), GP_OUT ([31] enable echo,
//             [30:12] block counter, [11:0] calibrated average), DONE,
//             DACA_CODE_OUT, DACB_CODE_OUT
module adc_dac_avg_loop
    import adc_dac_avg_loop_pkg::*;
(
    input  logic                ADC_CLK,
    input  logic                RST,
    adc_dac_avg_loop_if.slave   bus
);

    localparam int DAC_SHIFT = DAC_WIDTH - ADC_WIDTH;

    logic                     run_en;
    logic [AVG_LOG2-1:0]      sample_cnt;
    logic [ACC_WIDTH-1:0]     acc;
    logic [ACC_WIDTH-1:0]     sum_q;
    coef_t                    coef_q;
    logic [3:0]               stage_vld;
    logic [ADC_WIDTH-1:0]     avg_q;
    logic [ADC_WIDTH-1:0]     adcc;
    logic [DAC_WIDTH-1:0]     x_q;
    logic [BLK_CNT_WIDTH-1:0] blk_cnt;
    logic [BLK_CNT_WIDTH-1:0] blk_next;

    assign run_en   = bus.GP_IN[GP_EN_BIT];
    assign blk_next = blk_cnt + 1'b1;

    // Accumulation: while disabled the block state is held at zero, so a rising
    // enable always starts a fresh block and a falling one discards the partial
    // sum. The last sample is folded straight into the captured sum so the next
    // block starts on the very next clock.
    always_ff @(posedge ADC_CLK) begin
        if (RST) begin
            sample_cnt   <= '0;
            acc          <= '0;
            sum_q        <= '0;
            coef_q       <= '0;
            stage_vld[0] <= 1'b0;
        end else begin
            stage_vld[0] <= 1'b0;
            if (!run_en) begin
                sample_cnt <= '0;
                acc        <= '0;
            end else if (sample_cnt == '1) begin
                sum_q           <= acc + ACC_WIDTH'(bus.ADC_DATA_IN);
                coef_q.dac_gain <= cfg_word(bus.CFG_IN, W_DAC_GAIN);
                coef_q.dac_ofs  <= cfg_word(bus.CFG_IN, W_DAC_OFS);
                coef_q.adc_gain <= cfg_word(bus.CFG_IN, W_ADC_GAIN);
                coef_q.adc_ofs  <= cfg_word(bus.CFG_IN, W_ADC_OFS);
                acc             <= '0;
                sample_cnt      <= '0;
                stage_vld[0]    <= 1'b1;
            end else begin
                acc        <= acc + ACC_WIDTH'(bus.ADC_DATA_IN);
                sample_cnt <= sample_cnt + 1'b1;
            end
        end
    end

    // Average and DAC-width scaling stages; the valid chain tracks the block
    // through the pipeline so a reset flushes it without producing DONE.
    always_ff @(posedge ADC_CLK) begin
        if (RST) begin
            stage_vld[3:1] <= '0;
            avg_q          <= '0;
            x_q            <= '0;
        end else begin
            stage_vld[3:1] <= stage_vld[2:0];
            if (stage_vld[0]) begin
                avg_q <= sum_q[ACC_WIDTH-1:AVG_LOG2];
            end
            if (stage_vld[2]) begin
                x_q <= {adcc, {DAC_SHIFT{1'b0}}};
            end
        end
    end

    adc_dac_avg_loop_cal_mul_sat #(
        .IN_WIDTH  (ADC_WIDTH),
        .OUT_WIDTH (ADC_WIDTH)
    ) u_adc_cal (
        .clk    (ADC_CLK),
        .rst    (RST),
        .load   (stage_vld[1]),
        .x      (avg_q),
        .gain   (coef_q.adc_gain),
        .offset (coef_q.adc_ofs),
        .y      (adcc)
    );

    // Its output register is DACA_CODE_OUT itself, loaded on the DONE edge.
    adc_dac_avg_loop_cal_mul_sat #(
        .IN_WIDTH  (DAC_WIDTH),
        .OUT_WIDTH (DAC_WIDTH)
    ) u_daca_cal (
        .clk    (ADC_CLK),
        .rst    (RST),
        .load   (stage_vld[3]),
        .x      (x_q),
        .gain   (coef_q.dac_gain),
        .offset (coef_q.dac_ofs),
        .y      (bus.DACA_CODE_OUT)
    );

    // Status word and DONE share the DACA load edge. The calibrated average is
    // recovered from the top bits of the scaled value.
    always_ff @(posedge ADC_CLK) begin
        if (RST) begin
            bus.DONE          <= 1'b0;
            bus.GP_OUT        <= '0;
            bus.DACB_CODE_OUT <= '0;
            blk_cnt           <= '0;
        end else begin
            bus.DONE          <= stage_vld[3];
            bus.DACB_CODE_OUT <= bus.GP_IN[DAC_WIDTH-1:0];
            if (stage_vld[3]) begin
                blk_cnt    <= blk_next;
                bus.GP_OUT <= {run_en, blk_next, x_q[DAC_WIDTH-1 -: ADC_WIDTH]};
            end
        end
    end

endmodule

// File: tb/tb_adc_dac_avg_loop.sv
// tb_adc_dac_avg_loop
// Self-checking bench for adc_dac_avg_loop: a vector table of coefficient sets
// and ADC patterns, a scoreboard of expected block results consumed on DONE,
// plus hand-written reset, DAC-B, enable-abort and latency sequences.
module tb_adc_dac_avg_loop;
    import adc_dac_avg_loop_pkg::*;

    typedef struct {
        string       name;
        logic [31:0] ga;
        logic [31:0] oa;
        logic [31:0] gc;
        logic [31:0] oc;
        int          mode;
        logic [11:0] value;
        logic [13:0] exp_daca;
        logic [11:0] exp_adcc;
    } vec_t;

    typedef struct {
        string       name;
        logic [13:0] daca;
        logic [11:0] adcc;
    } exp_t;

    localparam logic [31:0] GA_DEF = 32'h0001_1D8F;
    localparam logic [31:0] OA_DEF = 32'hFFFF_FBD1;
    localparam logic [31:0] GC_DEF = 32'h0001_0000;
    localparam logic [31:0] OC_DEF = 32'h0000_0000;
    localparam logic [31:0] GP_RUN = 32'h8000_1234;

    logic ADC_CLK = 1'b0;
    logic RST;
    adc_dac_avg_loop_if bus ();

    adc_dac_avg_loop dut (
        .ADC_CLK (ADC_CLK),
        .RST     (RST),
        .bus     (bus)
    );

    always #5 ADC_CLK = ~ADC_CLK;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   done_last = 0;
    int   done_prev = 0;
    int   exp_blk = 0;
    exp_t sb[$];
    vec_t vecs[8];

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    function automatic logic [11:0] sample_of(input vec_t v, input int i);
        logic [11:0] s;
        s = (v.mode == 1) ? 12'(i) : v.value;
        return s;
    endfunction

    function automatic logic [CFG_WIDTH-1:0] make_cfg(input logic [31:0] ga, input logic [31:0] oa,
                                                      input logic [31:0] gc, input logic [31:0] oc);
        logic [CFG_WIDTH-1:0] c;
        c = '0;
        for (int k = 4; k < 32; k++) c[k*32 +: 32] = $urandom;
        c[W_DAC_GAIN*32 +: 32] = ga;
        c[W_DAC_OFS*32 +: 32]  = oa;
        c[W_ADC_GAIN*32 +: 32] = gc;
        c[W_ADC_OFS*32 +: 32]  = oc;
        return c;
    endfunction

    // Scoreboard consumer: every DONE must match the oldest pending block.
    always @(negedge ADC_CLK) begin
        exp_t e;
        cyc++;
        if (RST) begin
            exp_blk = 0;
        end else if (bus.DONE) begin
            done_prev = done_last;
            done_last = cyc;
            if (sb.size() == 0) begin
                check_output("unexpected_done", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                exp_blk++;
                check_output({e.name, "_daca"}, 32'(bus.DACA_CODE_OUT), 32'(e.daca));
                check_output({e.name, "_gp_avg"}, 32'(bus.GP_OUT[11:0]), 32'(e.adcc));
                check_output({e.name, "_gp_blk"}, 32'(bus.GP_OUT[30:12]), 32'(exp_blk));
                check_output({e.name, "_gp_en"}, 32'(bus.GP_OUT[31]), 32'd1);
            end
        end
    end

    task automatic push_exp(input string name, input logic [13:0] daca, input logic [11:0] adcc);
        exp_t e;
        e.name = name;
        e.daca = daca;
        e.adcc = adcc;
        sb.push_back(e);
    endtask

    // Waits (bounded) for every pending block to be reported.
    task automatic wait_drain(input string name);
        for (int k = 0; k < 20 && sb.size() != 0; k++) @(negedge ADC_CLK);
        check_output({name, "_drain_pending"}, 32'(sb.size()), 32'd0);
        sb.delete();
    endtask

    // Drives nblk back-to-back blocks, then scrambles CFG while the pipeline
    // still holds the captured block.
    task automatic apply_stimulus(input vec_t v, input int nblk);
        logic [CFG_WIDTH-1:0] c;
        c = make_cfg(v.ga, v.oa, v.gc, v.oc);
        bus.CFG_IN = c;
        bus.GP_IN  = GP_RUN;
        for (int b = 0; b < nblk; b++) push_exp(v.name, v.exp_daca, v.exp_adcc);
        for (int b = 0; b < nblk; b++) begin
            for (int i = 0; i < 1024; i++) begin
                bus.ADC_DATA_IN = sample_of(v, i);
                @(negedge ADC_CLK);
            end
        end
        bus.CFG_IN = ~c;
        wait_drain(v.name);
        bus.GP_IN = 32'h0;
        repeat (2) @(negedge ADC_CLK);
    endtask

    // Counts clocks from the current negedge to DONE with constant ADC input.
    task automatic measure_latency(input string name, input logic [11:0] adc);
        int n;
        n = 0;
        bus.ADC_DATA_IN = adc;
        for (int k = 1; k <= 1100; k++) begin
            @(negedge ADC_CLK);
            if (bus.DONE) begin
                n = k;
                break;
            end
        end
        check_output({name, "_latency"}, 32'(n), 32'd1028);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not complete, got timeout expected finish");
        errors++;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vecs[0] = '{"mid2048",   GA_DEF,       OA_DEF,       GC_DEF,       OC_DEF,       0, 12'd2048, 14'd8066,  12'd2048};
        vecs[1] = '{"zero",      GA_DEF,       OA_DEF,       GC_DEF,       OC_DEF,       0, 12'd0,    14'd0,     12'd0};
        vecs[2] = '{"full",      GA_DEF,       OA_DEF,       GC_DEF,       OC_DEF,       0, 12'd4095, 14'd16383, 12'd4095};
        vecs[3] = '{"ramp",      GA_DEF,       OA_DEF,       GC_DEF,       OC_DEF,       1, 12'd0,    14'd1209,  12'd511};
        vecs[4] = '{"half_adc",  32'h0001_0000, 32'd0,       32'h0000_8000, 32'd100,     0, 12'd1000, 14'd2400,  12'd600};
        vecs[5] = '{"adc_low",   32'h0001_0000, 32'd5,       32'h0001_0000, 32'hFFFF_F448, 0, 12'd1000, 14'd5,   12'd0};
        vecs[6] = '{"adc_high",  32'h0001_0000, 32'd0,       32'h0002_0000, 32'd0,       0, 12'd3000, 14'd16380, 12'd4095};
        vecs[7] = '{"half_dac",  32'h0000_8000, 32'd300,     32'h0001_0000, 32'd7,       0, 12'd1500, 14'd3314,  12'd1507};

        // Reset state, then idle with enable low.
        RST = 1'b1;
        bus.CFG_IN = '0;
        bus.ADC_DATA_IN = '0;
        bus.GP_IN = '0;
        repeat (3) @(negedge ADC_CLK);
        check_output("rst_done",   32'(bus.DONE), 32'd0);
        check_output("rst_daca",   32'(bus.DACA_CODE_OUT), 32'd0);
        check_output("rst_dacb",   32'(bus.DACB_CODE_OUT), 32'd0);
        check_output("rst_gp_out", bus.GP_OUT, 32'd0);
        RST = 1'b0;
        repeat (5) @(negedge ADC_CLK);
        check_output("idle_done",   32'(bus.DONE), 32'd0);
        check_output("idle_daca",   32'(bus.DACA_CODE_OUT), 32'd0);
        check_output("idle_gp_out", bus.GP_OUT, 32'd0);

        // DAC-B follows GP_IN one clock later.
        bus.GP_IN = GP_RUN;
        @(negedge ADC_CLK);
        check_output("dacb_copy", 32'(bus.DACB_CODE_OUT), 32'h1234);
        bus.GP_IN = 32'h0;
        repeat (2) @(negedge ADC_CLK);

        // Table of blocks; the first runs two blocks back to back.
        for (int t = 0; t < 8; t++) begin
            apply_stimulus(vecs[t], (t == 0) ? 2 : 1);
            if (t == 0) check_output("done_interval", 32'(done_last - done_prev), 32'd1024);
        end

        // Reset at sample 500 discards the block; a new one follows release.
        bus.CFG_IN = make_cfg(GA_DEF, OA_DEF, GC_DEF, OC_DEF);
        bus.GP_IN  = GP_RUN;
        bus.ADC_DATA_IN = 12'd2048;
        repeat (500) @(negedge ADC_CLK);
        RST = 1'b1;
        repeat (2) @(negedge ADC_CLK);
        check_output("midrst_done", 32'(bus.DONE), 32'd0);
        RST = 1'b0;
        push_exp("after_rst", 14'd8066, 12'd2048);
        measure_latency("after_rst", 12'd2048);
        wait_drain("after_rst");
        bus.GP_IN = 32'h0;
        repeat (2) @(negedge ADC_CLK);

        // Enable dropped mid-block: the partial sum must not leak.
        bus.GP_IN = GP_RUN;
        bus.ADC_DATA_IN = 12'd4095;
        repeat (600) @(negedge ADC_CLK);
        bus.GP_IN = 32'h0;
        repeat (3) @(negedge ADC_CLK);
        bus.GP_IN = GP_RUN;
        push_exp("after_abort", 14'd3390, 12'd1000);
        measure_latency("after_abort", 12'd1000);
        wait_drain("after_abort");
        bus.GP_IN = 32'h0;
        repeat (4) @(negedge ADC_CLK);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
